bitlet_group_accumulator: RTL and testbench

//  Accumulates a group of signed aligned partial sums from the Bitlet PE datapath into one wide sum.

---
 rtl/bitlet_group_accumulator.sv | 162 ++++++++++++++++
 tb/tb_bitlet_group_accumulator.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/bitlet_group_accumulator.sv
// bitlet_group_accumulator
//   Sums a group of signed aligned partial sums from the Bitlet PE datapath
//   into one wide accumulator. When the group is complete, it emits the sum and
//   the group's max exponent as a single-cycle valid pulse to the float32 packer.
//   There is no backpressure.
//
// Optional feature macro: BITLET_ACC_SAT_EN
//   defined   -> the accumulator saturates on overflow, then keeps accumulating
//   undefined -> the accumulator wraps (two's complement)
//   In both builds ovf reports that the group overflowed.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   cfg_len         partial sums per group (0 behaves as 1), taken on first psum
//   clr             synchronous abort of the group in progress
//   psum_vld, psum  signed partial sum input, at most one per cycle
//   emax            group max exponent, taken on first psum
//   busy            a group is in progress
//   Aacc_vld, Aacc  group sum pulse and value (value held between pulses)
//   Emax_vld, Emax  copy of Aacc_vld, exponent of the emitted group
//   ovf             group overflow flag, valid with Aacc_vld
module bitlet_group_accumulator #(
  parameter int W_PS  = 24,
  parameter int W_ACC = 40,
  parameter int W_EXS = 9,
  parameter int W_LEN = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W_LEN-1:0] cfg_len,
  input  logic             clr,
  input  logic             psum_vld,
  input  logic [W_PS-1:0]  psum,
  input  logic [W_EXS-1:0] emax,
  output logic             busy,
  output logic             Aacc_vld,
  output logic [W_ACC-1:0] Aacc,
  output logic             Emax_vld,
  output logic [W_EXS-1:0] Emax,
  output logic             ovf
);

  typedef enum logic {IDLE, ACC} state_t;

  state_t                   state, state_nxt;
  logic [W_LEN-1:0]         cnt, cnt_inc, len_q, len_eff;
  logic                     ovf_flag;
  logic signed [W_ACC-1:0]  acc_p0;
  logic [W_EXS-1:0]         emax_q;
  logic signed [W_ACC-1:0]  psum_ext, sum_raw, sum_nxt;
  logic                     ovf_now;
  logic                     start, accept, last;

  function automatic logic add_ovf(input logic signed [W_ACC-1:0] a,
                                   input logic signed [W_ACC-1:0] b,
                                   input logic signed [W_ACC-1:0] s);
    return (a[W_ACC-1] == b[W_ACC-1]) && (s[W_ACC-1] != a[W_ACC-1]);
  endfunction

`ifdef BITLET_ACC_SAT_EN
  function automatic logic signed [W_ACC-1:0] sat_value(input logic neg);
    return neg ? {1'b1, {(W_ACC-1){1'b0}}} : {1'b0, {(W_ACC-1){1'b1}}};
  endfunction
`endif

  assign len_eff  = (cfg_len == '0) ? W_LEN'(1) : cfg_len;
  assign cnt_inc  = cnt + W_LEN'(1);
  assign psum_ext = W_ACC'($signed(psum));
  assign sum_raw  = acc_p0 + psum_ext;
  assign ovf_now  = add_ovf(acc_p0, psum_ext, sum_raw);

`ifdef BITLET_ACC_SAT_EN
  // Both operands share a sign on overflow, so the clamp direction follows acc.
  assign sum_nxt = ovf_now ? sat_value(acc_p0[W_ACC-1]) : sum_raw;
`else
  assign sum_nxt = sum_raw;
`endif

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (psum_vld && !clr) begin
          start = 1'b1;
          if (len_eff == W_LEN'(1)) last = 1'b1;
          else                      state_nxt = ACC;
        end
      end
      ACC: begin
        if (clr) begin
          state_nxt = IDLE;
        end else if (psum_vld) begin
          accept = 1'b1;
          if (cnt_inc == len_q) begin
            last      = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: group control and accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      len_q    <= '0;
      ovf_flag <= 1'b0;
    end else begin
      state <= state_nxt;
      if (clr) begin
        cnt      <= '0;
        ovf_flag <= 1'b0;
      end else if (start) begin
        cnt      <= W_LEN'(1);
        len_q    <= len_eff;
        ovf_flag <= 1'b0;
      end else if (accept) begin
        cnt      <= last ? '0 : cnt_inc;
        ovf_flag <= ovf_flag | ovf_now;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      acc_p0 <= '0;
    end else if (start) begin
      acc_p0 <= psum_ext;
      emax_q <= emax;
    end else if (accept) begin
      acc_p0 <= sum_nxt;
    end
  end

  // Stage p1: result register, separate from acc so a new group can start
  // in the same cycle the previous result is presented
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Aacc_vld <= 1'b0;
      Aacc     <= '0;
      Emax     <= '0;
      ovf      <= 1'b0;
    end else begin
      Aacc_vld <= last;
      if (last) begin
        Aacc <= start ? psum_ext : sum_nxt;
        Emax <= start ? emax : emax_q;
        ovf  <= start ? 1'b0 : (ovf_flag | ovf_now);
      end
    end
  end

  assign Emax_vld = Aacc_vld;
  assign busy     = (state == ACC);

endmodule

// File: tb/tb_bitlet_group_accumulator.sv
module tb_bitlet_group_accumulator;

  localparam int W_PS  = 24;
  localparam int W_ACC = 40;
  localparam int W_EXS = 9;
  localparam int W_LEN = 12;

  logic             clk, rst_n;
  logic [W_LEN-1:0] cfg_len;
  logic             clr, psum_vld;
  logic [W_PS-1:0]  psum;
  logic [W_EXS-1:0] emax;
  logic             busy, Aacc_vld, Emax_vld, ovf;
  logic [W_ACC-1:0] Aacc;
  logic [W_EXS-1:0] Emax;

  // narrow instance for the overflow corner: W_ACC = W_PS + 1
  logic [W_LEN-1:0] cfg_len2;
  logic             clr2, psum_vld2;
  logic [7:0]       psum2;
  logic [W_EXS-1:0] emax2;
  logic             busy2, aacc_vld2, emax_vld2, ovf2;
  logic [8:0]       aacc2;
  logic [W_EXS-1:0] emax_o2;

  bitlet_group_accumulator #(.W_PS(W_PS), .W_ACC(W_ACC), .W_EXS(W_EXS), .W_LEN(W_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_len(cfg_len), .clr(clr), .psum_vld(psum_vld),
    .psum(psum), .emax(emax), .busy(busy), .Aacc_vld(Aacc_vld), .Aacc(Aacc),
    .Emax_vld(Emax_vld), .Emax(Emax), .ovf(ovf));

  bitlet_group_accumulator #(.W_PS(8), .W_ACC(9), .W_EXS(W_EXS), .W_LEN(W_LEN)) dut2 (
    .clk(clk), .rst_n(rst_n), .cfg_len(cfg_len2), .clr(clr2), .psum_vld(psum_vld2),
    .psum(psum2), .emax(emax2), .busy(busy2), .Aacc_vld(aacc_vld2), .Aacc(aacc2),
    .Emax_vld(emax_vld2), .Emax(emax_o2), .ovf(ovf2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference model: true-integer group sum with range fold/clamp per add.
  localparam longint ACC_MAX = (64'sd1 <<< (W_ACC-1)) - 1;
  localparam longint ACC_MIN = -(64'sd1 <<< (W_ACC-1));
  bit     m_busy = 0;
  int     m_cnt, m_len, m_emax;
  longint m_sum;
  bit     m_ovf;
  longint last_res = 0;
  int     last_e   = 0;
  bit     last_o   = 0;
  bit     got_pulse;

  task automatic model(input bit v, input bit c, input int len, input longint ps,
                       input int em, output bit pulse);
    pulse = 0;
    if (c) begin m_busy = 0; return; end
    if (!v) return;
    if (!m_busy) begin
      m_busy = 1; m_cnt = 0; m_len = (len == 0) ? 1 : len;
      m_sum = 0; m_ovf = 0; m_emax = em;
    end
    m_sum += ps;
    m_cnt++;
    if (m_sum > ACC_MAX) begin
      m_ovf = 1;
`ifdef BITLET_ACC_SAT_EN
      m_sum = ACC_MAX;
`else
      m_sum = m_sum - (ACC_MAX - ACC_MIN + 1);
`endif
    end else if (m_sum < ACC_MIN) begin
      m_ovf = 1;
`ifdef BITLET_ACC_SAT_EN
      m_sum = ACC_MIN;
`else
      m_sum = m_sum + (ACC_MAX - ACC_MIN + 1);
`endif
    end
    if (m_cnt == m_len) begin
      pulse = 1; last_res = m_sum; last_e = m_emax; last_o = m_ovf; m_busy = 0;
    end
  endtask

  task automatic step(input bit v, input bit c, input int len, input longint ps, input int em);
    psum_vld = v; clr = c; cfg_len = len[W_LEN-1:0]; psum = ps[W_PS-1:0]; emax = em[W_EXS-1:0];
    @(posedge clk); #1;
    model(v, c, len, ps, em, got_pulse);
    chk("aacc_vld", longint'(Aacc_vld), longint'(got_pulse));
    chk("emax_vld", longint'(Emax_vld), longint'(got_pulse));
    chk("busy", longint'(busy), longint'(m_busy));
    chk("aacc", longint'($signed(Aacc)), last_res);
    chk("emax", longint'(Emax), longint'(last_e));
    if (got_pulse) chk("ovf", longint'(ovf), longint'(last_o));
    psum_vld = 0; clr = 0;
  endtask

  typedef struct {
    int              len;
    int              em;
    int              n;
    logic [3:0][23:0] ps;
    longint          exp;
  } vec_t;

  vec_t vt[5];

  initial begin
    longint ex2;
    logic signed [W_PS-1:0] r;
    vt[0] = '{len: 4, em: 130, n: 4, ps: {24'd7, 24'd10, -24'sd3, 24'd5}, exp: 19};
    vt[1] = '{len: 0, em: 7,   n: 1, ps: {72'd0, 24'd100},               exp: 100};
    vt[2] = '{len: 0, em: 8,   n: 1, ps: {72'd0, -24'sd100},             exp: -100};
    vt[3] = '{len: 2, em: 255, n: 2, ps: {48'd0, 24'h800000, 24'h800000}, exp: -16777216};
    vt[4] = '{len: 1, em: 0,   n: 1, ps: {72'd0, 24'h7FFFFF},            exp: 8388607};

    rst_n = 1; cfg_len = 0; clr = 0; psum_vld = 0; psum = 0; emax = 0;
    cfg_len2 = 0; clr2 = 0; psum_vld2 = 0; psum2 = 0; emax2 = 0;
    #1 rst_n = 0;
    #2;
    chk("rst_aacc_vld", longint'(Aacc_vld), 0);
    chk("rst_aacc", longint'(Aacc), 0);
    chk("rst_emax", longint'(Emax), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_ovf", longint'(ovf), 0);
    @(posedge clk); #1 rst_n = 1;

    // table groups, applied back to back with no idle cycles
    for (int g = 0; g < 5; g++) begin
      for (int k = 0; k < vt[g].n; k++)
        step(1, 0, vt[g].len, longint'($signed(vt[g].ps[k])), vt[g].em);
      chk("tbl_pulse", longint'(Aacc_vld), 1);
      chk("tbl_sum", longint'($signed(Aacc)), vt[g].exp);
      chk("tbl_emax", longint'(Emax), longint'(vt[g].em));
    end
    step(0, 0, 0, 0, 0);

    // clr together with the last psum drops the group
    step(1, 0, 3, 1, 11);
    step(1, 0, 3, 2, 11);
    step(1, 1, 3, 4, 11);
    step(0, 0, 0, 0, 0);
    chk("clr_no_pulse", longint'(Aacc_vld), 0);
    step(1, 0, 1, 9, 12);
    chk("after_clr_sum", longint'($signed(Aacc)), 9);

    // gaps inside a group; cfg_len/emax changes mid-group are ignored
    step(1, 0, 3, 1, 40);
    step(1, 0, 1, 1, 41);
    repeat (5) step(0, 0, 1, 0, 42);
    step(1, 0, 1, 1, 43);
    chk("gap_sum", longint'($signed(Aacc)), 3);
    chk("gap_emax", longint'(Emax), 40);
    repeat (2) step(0, 0, 0, 0, 0);

    // overflow on the narrow instance: 127+127+127 in 9 bits
`ifdef BITLET_ACC_SAT_EN
    ex2 = 255;
`else
    ex2 = -131;
`endif
    for (int k = 0; k < 3; k++) begin
      cfg_len2 = 3; psum_vld2 = 1; psum2 = 8'd127; emax2 = 9'd5;
      @(posedge clk); #1;
      chk("n_vld", longint'(aacc_vld2), (k == 2) ? 1 : 0);
    end
    psum_vld2 = 0;
    chk("n_sum", longint'($signed(aacc2)), ex2);
    chk("n_ovf", longint'(ovf2), 1);
    chk("n_emax", longint'(emax_o2), 5);

    // asynchronous reset mid-group
    step(1, 0, 4, 50, 3);
    step(1, 0, 4, 60, 3);
    #1 rst_n = 0;
    #1;
    chk("mid_rst_aacc", longint'(Aacc), 0);
    chk("mid_rst_emax", longint'(Emax), 0);
    chk("mid_rst_busy", longint'(busy), 0);
    chk("mid_rst_vld", longint'(Aacc_vld), 0);
    m_busy = 0; last_res = 0; last_e = 0; last_o = 0;
    @(posedge clk); #2 rst_n = 1;
    for (int k = 1; k <= 4; k++) step(1, 0, 4, k, 77);
    chk("post_rst_sum", longint'($signed(Aacc)), 10);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      r = W_PS'($urandom);
      step(($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0),
           $urandom_range(0, 5), longint'(r), $urandom_range(0, 511));
    end
    repeat (6) step(0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
